// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry and a ceil-log2 helper.
// Used by both the synchronous and asynchronous FIFO families.
package fifo_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DEFAULT_DEPTH = 16;

   // Smallest n such that 2**n >= value (returns 0 for value <= 1).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH array, synchronous write port, asynchronous read port.
// Contents are never reset; only the pointers in the owning FIFO define what is valid.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   parameter int unsigned AW    = clog2(DEFAULT_DEPTH)
) (
   input  logic             clk_i,
   input  logic             w_en_i,
   input  logic [AW-1:0]    w_addr_i,
   input  logic [WIDTH-1:0] w_data_i,
   input  logic [AW-1:0]    r_addr_i,
   output logic [WIDTH-1:0] r_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port: one word per accepted write.
   always_ff @(posedge clk_i) begin
      if (w_en_i) begin
         mem_q[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and
// show-ahead read data. Optional sticky overflow/underflow flags are built only
// when SYNC_FIFO_ERR_EN is defined; otherwise both outputs are tied low.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned AFULL_TH  = 12,
   parameter int unsigned AEMPTY_TH = 4,
   localparam int unsigned AW       = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wEn,
   input  logic [WIDTH-1:0] wData,
   input  logic             rEn,
   output logic [WIDTH-1:0] rData,
   output logic             full,
   output logic             empty,
   output logic             almostFull,
   output logic             almostEmpty,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0] DepthC  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AfullC  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AemptyC = (AW+1)'(AEMPTY_TH);
   localparam logic [AW:0] OneC    = (AW+1)'(1);

   logic [AW:0] w_ptr_q, w_ptr_d;
   logic [AW:0] r_ptr_q, r_ptr_d;
   logic [AW:0] count_q, count_d;
   logic        w_acc, r_acc;

   // Flags come only from the registered count, so accepts see last cycle's state.
   assign full        = (count_q == DepthC);
   assign empty       = (count_q == '0);
   assign almostFull  = (count_q >= AfullC);
   assign almostEmpty = (count_q <= AemptyC);
   assign count       = count_q;

   // A write is allowed at full only when a read frees the same slot this edge.
   assign w_acc = wEn & (~full | rEn);
   assign r_acc = rEn & ~empty;

   // Next-state pointers and occupancy.
   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      if (w_acc) begin
         w_ptr_d = w_ptr_q + OneC;
      end
      if (r_acc) begin
         r_ptr_d = r_ptr_q + OneC;
      end
      unique case ({w_acc, r_acc})
         2'b10:   count_d = count_q + OneC;
         2'b01:   count_d = count_q - OneC;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count state, synchronous reset wins over any request.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i    (clk),
      .w_en_i   (w_acc),
      .w_addr_i (w_ptr_q[AW-1:0]),
      .w_data_i (wData),
      .r_addr_i (r_ptr_q[AW-1:0]),
      .r_data_o (rData)
   );

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error capture: dropped write at full, read attempted while empty.
   always_comb begin
      overflow_d  = overflow_q | (wEn & full & ~rEn);
      underflow_d = underflow_q | (rEn & empty);
   end

   // Error flags clear only on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

`ifndef SYNTHESIS
   // Pointer difference and the count register are two views of the same occupancy.
   a_count_matches_ptrs : assert property (@(posedge clk) disable iff (rst)
      (w_ptr_q - r_ptr_q) == count_q);
   a_count_in_range : assert property (@(posedge clk) disable iff (rst)
      count_q <= DepthC);
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (WIDTH=32, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2).
// A queue holds every word the producer model expects to come back out.
module tb_sync_fifo;

   localparam int D = 8;

`ifdef SYNC_FIFO_ERR_EN
   localparam logic ErrEn = 1'b1;
`else
   localparam logic ErrEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        w_en;
   logic [31:0] w_data;
   logic        r_en;
   logic [31:0] r_data;
   logic        full, empty, a_full, a_empty, ovf, unf;
   logic [3:0]  count;

   logic [31:0] sb_q [$];
   logic        pop_valid;
   logic [31:0] pop_seen;
   logic [31:0] pop_exp;
   int          total = 0;
   int          bad = 0;

   sync_fifo #(
      .WIDTH     (32),
      .DEPTH     (D),
      .AFULL_TH  (6),
      .AEMPTY_TH (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wEn         (w_en),
      .wData       (w_data),
      .rEn         (r_en),
      .rData       (r_data),
      .full        (full),
      .empty       (empty),
      .almostFull  (a_full),
      .almostEmpty (a_empty),
      .count       (count),
      .overflow    (ovf),
      .underflow   (unf)
   );

   always #5 clk = ~clk;

   // Drive one cycle; the model decides acceptance from its own occupancy.
   task automatic clk_step(input logic w, input logic [31:0] d, input logic r);
      logic wacc, racc;
      wacc = w && ((sb_q.size() < D) || r);
      racc = r && (sb_q.size() > 0);
      w_en = w; w_data = d; r_en = r;
      pop_valid = racc;
      pop_seen  = r_data;
      pop_exp   = 32'h0;
      if (racc) pop_exp = sb_q.pop_front();
      if (wacc) sb_q.push_back(d);
      @(posedge clk); #1;
      w_en = 1'b0; r_en = 1'b0;
   endtask

   task automatic do_reset(input logic w, input logic r);
      rst = 1'b1; w_en = w; r_en = r; w_data = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
      sb_q.delete();
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
      total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b want=1", a_empty); end
      total++; if (a_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b want=0", a_full); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
      total++; if (unf !== 1'b0) begin bad++; $display("FAIL reset_unf got=%b want=0", unf); end
   endtask

   task automatic test_fill_drain();
      do_reset(1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         clk_step(1'b1, 32'h11 * k, 1'b0);
         total++; if (count !== 4'(k)) begin bad++; $display("FAIL fill_count k=%0d got=%0d want=%0d", k, count, k); end
         total++; if (a_empty !== (k <= 2)) begin bad++; $display("FAIL fill_aempty k=%0d got=%b want=%b", k, a_empty, (k <= 2)); end
         total++; if (a_full !== (k >= 6)) begin bad++; $display("FAIL fill_afull k=%0d got=%b want=%b", k, a_full, (k >= 6)); end
         total++; if (full !== (k == 8)) begin bad++; $display("FAIL fill_full k=%0d got=%b want=%b", k, full, (k == 8)); end
      end
      for (int k = 1; k <= 8; k++) begin
         clk_step(1'b0, 32'h0, 1'b1);
         total++; if (pop_seen !== 32'h11 * k) begin bad++; $display("FAIL drain_data k=%0d got=%h want=%h", k, pop_seen, 32'h11 * k); end
         total++; if (count !== 4'(8 - k)) begin bad++; $display("FAIL drain_count k=%0d got=%0d want=%0d", k, count, 8 - k); end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
   endtask

   task automatic test_overflow();
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 8; k++) clk_step(1'b1, 32'h100 + k, 1'b0);
      clk_step(1'b1, 32'hDEAD, 1'b0);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", count); end
      total++; if (ovf !== ErrEn) begin bad++; $display("FAIL ovf_flag got=%b want=%b", ovf, ErrEn); end
      for (int k = 0; k < 8; k++) begin
         clk_step(1'b0, 32'h0, 1'b1);
         total++; if (pop_seen !== 32'h100 + k) begin bad++; $display("FAIL ovf_drain k=%0d got=%h want=%h", k, pop_seen, 32'h100 + k); end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b want=1", empty); end
      total++; if (ovf !== ErrEn) begin bad++; $display("FAIL ovf_sticky got=%b want=%b", ovf, ErrEn); end
   endtask

   task automatic test_full_rw();
      do_reset(1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) clk_step(1'b1, 32'h11 * k, 1'b0);
      clk_step(1'b1, 32'hAA, 1'b1);
      total++; if (pop_seen !== 32'h11) begin bad++; $display("FAIL fullrw_head got=%h want=11", pop_seen); end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL fullrw_count got=%0d want=8", count); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b want=0", ovf); end
      for (int k = 0; k < 8; k++) begin
         clk_step(1'b0, 32'h0, 1'b1);
         total++; if (pop_seen !== pop_exp) begin bad++; $display("FAIL fullrw_drain k=%0d got=%h want=%h", k, pop_seen, pop_exp); end
      end
      total++; if (pop_seen !== 32'hAA) begin bad++; $display("FAIL fullrw_last got=%h want=aa", pop_seen); end
   endtask

   task automatic test_empty_rw();
      do_reset(1'b0, 1'b0);
      clk_step(1'b1, 32'h5A, 1'b1);
      total++; if (count !== 4'd1) begin bad++; $display("FAIL emptyrw_count got=%0d want=1", count); end
      total++; if (r_data !== 32'h5A) begin bad++; $display("FAIL emptyrw_data got=%h want=5a", r_data); end
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL emptyrw_empty got=%b want=0", empty); end
      total++; if (unf !== ErrEn) begin bad++; $display("FAIL emptyrw_unf got=%b want=%b", unf, ErrEn); end
   endtask

   task automatic test_stream();
      int writes = 0;
      logic w, r;
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 120; i++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         if (w && (sb_q.size() < D || r)) writes++;
         clk_step(w, $urandom, r);
         if (pop_valid) begin
            total++; if (pop_seen !== pop_exp) begin bad++; $display("FAIL stream_data i=%0d got=%h want=%h", i, pop_seen, pop_exp); end
         end
         total++; if (count !== 4'(sb_q.size())) begin bad++; $display("FAIL stream_count i=%0d got=%0d want=%0d", i, count, sb_q.size()); end
         total++; if (count > 4'd8) begin bad++; $display("FAIL stream_range i=%0d got=%0d want<=8", i, count); end
         total++; if (empty !== (sb_q.size() == 0)) begin bad++; $display("FAIL stream_empty i=%0d got=%b want=%b", i, empty, (sb_q.size() == 0)); end
      end
      total++; if (writes < 2 * D) begin bad++; $display("FAIL stream_wraps got=%0d want>=%0d", writes, 2 * D); end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) clk_step(1'b1, 32'h200 + k, 1'b0);
      clk_step(1'b0, 32'h0, 1'b1);
      clk_step(1'b0, 32'h0, 1'b1);
      clk_step(1'b0, 32'h0, 1'b1);
      clk_step(1'b0, 32'h0, 1'b1);
      clk_step(1'b0, 32'h0, 1'b1);
      clk_step(1'b0, 32'h0, 1'b1);
      clk_step(1'b1, 32'h300, 1'b0);
      clk_step(1'b1, 32'h301, 1'b0);
      do_reset(1'b1, 1'b1);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%b want=1", empty); end
      total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL rstmid_aempty got=%b want=1", a_empty); end
      total++; if (a_full !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%b%b want=00", a_full, full); end
      total++; if (ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b%b want=00", ovf, unf); end
      clk_step(1'b1, 32'h77, 1'b0);
      total++; if (r_data !== 32'h77) begin bad++; $display("FAIL rstmid_data got=%h want=77", r_data); end
      total++; if (count !== 4'd1) begin bad++; $display("FAIL rstmid_count1 got=%0d want=1", count); end
   endtask

   initial begin
      rst = 1'b1; w_en = 1'b0; r_en = 1'b0; w_data = 32'h0;
      pop_valid = 1'b0; pop_seen = 32'h0; pop_exp = 32'h0;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_rw();
      test_empty_rw();
      test_stream();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
